// File: rtl/mod_mul_arbiter.sv
// Round-robin arbiter that shares one modular multiplier among NREQ
// requesters. A granted requester keeps the multiplier from operand latch
// through its one-cycle done pulse; the FSM then returns to IDLE and
// re-arbitrates from the slot after the last winner.
module mod_mul_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic [NREQ-1:0]   grant,
   output logic [NREQ-1:0]   done,
   output logic [W-1:0]      result,
   output logic              busy,
   output logic              mul_start,
   output logic [W-1:0]      mul_a,
   output logic [W-1:0]      mul_b,
   input  logic [W-1:0]      mul_result,
   input  logic              mul_done
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     ptr_q, ptr_d;
   logic [NREQ-1:0]   grant_q, grant_d;
   logic [NREQ-1:0]   done_q, done_d;
   logic [W-1:0]      result_q, result_d;
   logic [W-1:0]      mula_q, mula_d;
   logic [W-1:0]      mulb_q, mulb_d;
   logic              start_q, start_d;

   // Round-robin search results
   logic              sel_found;
   logic [PW-1:0]     sel_idx;
   logic [W-1:0]      sel_a;
   logic [W-1:0]      sel_b;
   int                cand;

   // Find the first requester at or above ptr, wrapping past NREQ-1 to 0
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      sel_a     = '0;
      sel_b     = '0;
      cand      = 0;
      for (int i = 0; i < NREQ; i++) begin
         cand = (int'(ptr_q) + i) % NREQ;
         if (!sel_found && req[PW'(cand)]) begin
            sel_found = 1'b1;
            sel_idx   = PW'(cand);
         end
      end
      // Operand mux uses constant part-selects over the winner index
      for (int j = 0; j < NREQ; j++) begin
         if (sel_idx == PW'(j)) begin
            sel_a = req_a[j*W +: W];
            sel_b = req_b[j*W +: W];
         end
      end
   end

   // Next-state and registered-output logic; everything holds by default
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      grant_d  = grant_q;
      done_d   = '0;
      result_d = result_q;
      mula_d   = mula_q;
      mulb_d   = mulb_q;
      start_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (sel_found) begin
               grant_d          = '0;
               grant_d[sel_idx] = 1'b1;
               mula_d           = sel_a;
               mulb_d           = sel_b;
               start_d          = 1'b1;
               ptr_d            = (sel_idx == PW'(NREQ - 1)) ? '0 : sel_idx + 1'b1;
               state_d          = ISSUE;
            end
         end
         ISSUE: begin
            state_d = WAIT;
         end
         WAIT: begin
            // No timeout: the multiplier is trusted to finish eventually
            if (mul_done) begin
               result_d = mul_result;
               done_d   = grant_q;
               state_d  = RESP;
            end
         end
         RESP: begin
            grant_d = '0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset also clears operands and result
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         grant_q  <= '0;
         done_q   <= '0;
         result_q <= '0;
         mula_q   <= '0;
         mulb_q   <= '0;
         start_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         grant_q  <= grant_d;
         done_q   <= done_d;
         result_q <= result_d;
         mula_q   <= mula_d;
         mulb_q   <= mulb_d;
         start_q  <= start_d;
      end
   end

   assign grant     = grant_q;
   assign done      = done_q;
   assign result    = result_q;
   assign busy      = (state_q != IDLE);
   assign mul_start = start_q;
   assign mul_a     = mula_q;
   assign mul_b     = mulb_q;

endmodule

// File: tb/tb_mod_mul_arbiter.sv
// Directed bench for mod_mul_arbiter with a 5-cycle multiplier model.
module tb_mod_mul_arbiter;

   localparam int NREQ = 4;
   localparam int W    = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NREQ-1:0]   req = '0;
   logic [NREQ*W-1:0] req_a = '0;
   logic [NREQ*W-1:0] req_b = '0;
   logic [NREQ-1:0]   grant;
   logic [NREQ-1:0]   done;
   logic [W-1:0]      result;
   logic              busy;
   logic              mul_start;
   logic [W-1:0]      mul_a;
   logic [W-1:0]      mul_b;
   logic [W-1:0]      mul_result;
   logic              mul_done;

   // Multiplier model state
   int                mdl_cnt = 0;
   logic [W-1:0]      mdl_prod = '0;
   logic [W-1:0]      mdl_res = '0;
   logic              mdl_done = 1'b0;
   logic              spur_done = 1'b0;

   int                total = 0;
   int                passed = 0;
   int                oh_bad = 0;
   int                starts = 0;

   mod_mul_arbiter #(.NREQ(NREQ), .W(W)) dut (
      .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
      .grant(grant), .done(done), .result(result), .busy(busy),
      .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
      .mul_result(mul_result), .mul_done(mul_done)
   );

   always #5 clk = ~clk;

   assign mul_done   = mdl_done | spur_done;
   assign mul_result = mdl_res;

   // Multiplier model: done pulse five cycles after the start pulse
   always @(posedge clk) begin
      if (rst) begin
         mdl_cnt  <= 0;
         mdl_done <= 1'b0;
      end else begin
         mdl_done <= 1'b0;
         if (mul_start) begin
            mdl_cnt  <= 4;
            mdl_prod <= mul_a * mul_b;
         end else if (mdl_cnt != 0) begin
            mdl_cnt <= mdl_cnt - 1;
            if (mdl_cnt == 1) begin
               mdl_done <= 1'b1;
               mdl_res  <= mdl_prod;
            end
         end
      end
   end

   // Monitors: one-hot-or-zero grant/done, and start pulse count
   always @(negedge clk) begin
      if (!$onehot0(grant) || !$onehot0(done)) oh_bad++;
      if (mul_start) starts++;
   end

   typedef struct {
      int          idx;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp;
   } vec_t;

   vec_t tbl [4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else passed++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (done == '0 && n < 40) begin
         tick();
         n++;
      end
   endtask

   task automatic set_ops(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
      req_a[idx*W +: W] = a;
      req_b[idx*W +: W] = b;
   endtask

   // One isolated request with full latency checks
   task automatic do_single(input string nm, input int idx, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] exp);
      int n;
      set_ops(idx, a, b);
      req[idx] = 1'b1;
      tick();
      chk({nm, ".start"}, 64'(mul_start), 64'd1);
      chk({nm, ".grant"}, 64'(grant), 64'(4'b0001 << idx));
      chk({nm, ".mul_a"}, 64'(mul_a), 64'(a));
      wait_done(n);
      chk({nm, ".lat"}, 64'(n), 64'd6);
      chk({nm, ".done"}, 64'(done), 64'(4'b0001 << idx));
      chk({nm, ".result"}, 64'(result), 64'(exp));
      req[idx] = 1'b0;
      tick();
      chk({nm, ".idle"}, {busy, grant, done}, 64'd0);
   endtask

   initial begin
      int n;
      int s0;
      int bad;

      tbl[0] = '{0, 32'd3, 32'd5, 32'd15};
      tbl[1] = '{2, 32'd100, 32'd200, 32'd20000};
      tbl[2] = '{3, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF};
      tbl[3] = '{1, 32'h00010000, 32'h00010000, 32'h00000000};

      // Reset state
      do_reset();
      chk("rst.outs", {grant, done, busy, mul_start}, 64'd0);
      chk("rst.ops", {mul_a, mul_b}, 64'd0);
      chk("rst.result", 64'(result), 64'd0);

      // Single requests from the table
      for (int i = 0; i < 4; i++)
         do_single($sformatf("vec%0d", i), tbl[i].idx, tbl[i].a, tbl[i].b, tbl[i].exp);

      // Contention: all four hold req, served 0,1,2,3
      do_reset();
      for (int i = 0; i < NREQ; i++) set_ops(i, W'(i + 2), W'(i + 3));
      s0 = starts;
      req = 4'b1111;
      for (int k = 0; k < NREQ; k++) begin
         wait_done(n);
         chk($sformatf("cont%0d.done", k), 64'(done), 64'(4'b0001 << k));
         chk($sformatf("cont%0d.grant", k), 64'(grant), 64'(4'b0001 << k));
         chk($sformatf("cont%0d.result", k), 64'(result), 64'((k + 2) * (k + 3)));
         req[k] = 1'b0;
         tick();
      end
      tick();
      chk("cont.idle", 64'(busy), 64'd0);
      chk("cont.starts", 64'(starts - s0), 64'd4);

      // Fairness wrap: grant to 2 leaves ptr=3
      do_reset();
      do_single("fair.pre", 2, 32'd2, 32'd2, 32'd4);
      set_ops(3, 32'd4, 32'd5);
      set_ops(0, 32'd2, 32'd9);
      req = 4'b1001;
      tick();
      chk("fair.grant3", 64'(grant), 64'b1000);
      wait_done(n);
      chk("fair.done3", 64'(done), 64'b1000);
      chk("fair.res3", 64'(result), 64'd20);
      req[3] = 1'b0;
      tick();
      wait_done(n);
      chk("fair.done0", 64'(done), 64'b0001);
      chk("fair.res0", 64'(result), 64'd18);
      req[0] = 1'b0;
      tick();
      set_ops(1, 32'd3, 32'd3);
      req = 4'b0011;
      tick();
      chk("fair.ptr1", 64'(grant), 64'b0010);
      wait_done(n);
      chk("fair.done1", 64'(done), 64'b0010);
      chk("fair.res1", 64'(result), 64'd9);
      req[1] = 1'b0;
      tick();
      wait_done(n);
      chk("fair.done0b", 64'(done), 64'b0001);
      req = '0;
      tick();

      // Reset two cycles after mul_start
      set_ops(0, 32'd8, 32'd8);
      req = 4'b0001;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("rstw.outs", {grant, done, busy, mul_start}, 64'd0);
      chk("rstw.ops", {mul_a, mul_b}, 64'd0);
      chk("rstw.result", 64'(result), 64'd0);
      rst = 1'b0;
      req = '0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (done != '0 || busy) bad++;
         tick();
      end
      chk("rstw.nodone", 64'(bad), 64'd0);
      do_single("rstw.fresh", 1, 32'd6, 32'd7, 32'd42);

      // Spurious mul_done in IDLE and ISSUE
      spur_done = 1'b1;
      tick();
      spur_done = 1'b0;
      chk("spur.idle", {busy, grant, done, mul_start}, 64'd0);
      set_ops(2, 32'd7, 32'd9);
      req = 4'b0100;
      tick();
      spur_done = 1'b1;
      tick();
      spur_done = 1'b0;
      chk("spur.issue", {busy, grant, done}, {55'd0, 1'b1, 4'b0100, 4'b0000});
      wait_done(n);
      chk("spur.lat", 64'(n), 64'd5);
      chk("spur.done", 64'(done), 64'b0100);
      chk("spur.result", 64'(result), 64'd63);
      req = '0;
      tick();

      // Non-owner operand churn during owner's WAIT
      tick();
      set_ops(0, 32'd11, 32'd13);
      req = 4'b0001;
      tick();
      tick();
      req[1] = 1'b1;
      set_ops(1, 32'd5, 32'd5);
      tick();
      chk("stab.mul_a1", 64'(mul_a), 64'd11);
      chk("stab.grant", 64'(grant), 64'b0001);
      set_ops(1, 32'd99, 32'd77);
      tick();
      chk("stab.mul_a2", 64'(mul_a), 64'd11);
      chk("stab.mul_b2", 64'(mul_b), 64'd13);
      wait_done(n);
      chk("stab.done", 64'(done), 64'b0001);
      chk("stab.result", 64'(result), 64'd143);
      req = '0;
      tick();
      chk("stab.idle", 64'(busy), 64'd0);

      chk("onehot", 64'(oh_bad), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mod_mul_arbiter.md
MOD_MUL_ARBITER -- requirements
Module: mod_mul_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one mod_mul.
REQ-002 SHALL have parameter W, default 256, operand/result width.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port req, input, NREQ, per-requester level request; operands held stable while high.
REQ-006 SHALL have port req_a, input, NREQ*W, operand a; requester i at bits [i*W +: W].
REQ-007 SHALL have port req_b, input, NREQ*W, operand b; same packing as req_a.
REQ-008 SHALL have port grant, output, NREQ, one-hot owner of the multiplier; all-zero when idle.
REQ-009 SHALL have port done, output, NREQ, one-cycle completion pulse to the owner.
REQ-010 SHALL have port result, output, W, product; valid only while a done bit is high.
REQ-011 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-012 SHALL have port mul_start, output, 1, one-cycle start pulse to the mod_mul.
REQ-013 SHALL have ports mul_a and mul_b, output, W each, registered operands to the mod_mul.
REQ-014 SHALL have port mul_result, input, W, mod_mul product.
REQ-015 SHALL have port mul_done, input, 1, mod_mul completion pulse.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-017 IDLE: if any req bit is high, SHALL select a winner round-robin, latch winner's req_a/req_b into mul_a/mul_b, set grant one-hot, and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-018 Round-robin SHALL search from index ptr upward with wrap-around (NREQ-1 -> 0); ptr SHALL become winner+1 mod NREQ at grant.
REQ-019 ISSUE: mul_start SHALL be 1 for exactly this one cycle; next state WAIT.
REQ-020 WAIT: on mul_done=1, SHALL register mul_result into result and go to RESP; otherwise SHALL stay in WAIT indefinitely, with no timeout.
REQ-021 RESP: done[owner] SHALL be 1 for this one cycle, with result valid; grant SHALL clear to zero on exit; next state IDLE.
REQ-022 Latency: req sampled in IDLE at cycle t gives mul_start at t+1; mul_done at cycle k gives done at k+1; the next grant is no earlier than k+2.
REQ-023 Requesters SHALL drop req on the clock edge ending their done cycle; a req still high in the following IDLE SHALL be treated as a new request.
REQ-024 mul_done seen in IDLE, ISSUE or RESP SHALL be ignored.
REQ-025 req changes on non-owners during ISSUE/WAIT/RESP SHALL NOT affect mul_a, mul_b, grant or ptr.
REQ-026 Owner dropping req mid-operation SHALL NOT abort the operation; done still pulses to that owner.
REQ-027 mul_a and mul_b SHALL stay constant from grant until exit from RESP.
REQ-028 At most one bit of done and of grant SHALL be high in any cycle.

Reset
REQ-029 rst=1 SHALL force state IDLE, ptr=0, grant=0, done=0, mul_start=0, busy=0, mul_a=0, mul_b=0, result=0 on the next edge, including mid-operation.
REQ-030 An operation interrupted by reset SHALL produce no done pulse; the mod_mul SHALL share rst so it aborts too.

Verification
REQ-031 Single request: bench mul model with 5-cycle latency; req=0001, a=3, b=5 -> mul_start at t+1, done=0001 with result=15 at t+7, busy low at t+8.
REQ-032 Contention: req=1111 held, each requester dropping req after its done -> grant order 0,1,2,3; exactly four mul_start pulses; no overlap.
REQ-033 Fairness wrap: ptr=3 after a previous grant to 2, req=1001 -> requester 3 granted first, then 0; ptr=1 afterwards.
REQ-034 Reset mid-WAIT: assert rst 2 cycles after mul_start -> all outputs 0 next edge, no done pulse; a fresh req=0010 then completes normally.
REQ-035 Spurious mul_done in IDLE and ISSUE -> ignored; state and outputs unchanged; correct result still delivered at the real mul_done.
REQ-036 Operand stability: toggle req_a of non-owner 1 during WAIT of owner 0 -> mul_a unchanged, owner 0 gets the correct product.
